// File: rtl/dab_pattern_monitor_if.sv
// rtl/dab_pattern_monitor_if.sv - signal bundle for the dual-active-bridge gate-pattern monitor
//
// Purpose: groups the gate inputs, fault clear and measurement outputs of
// dab_pattern_monitor so that the design and its driver share one port.
// Signals:
//   Sp, Ss      [3:0]  primary / secondary gates ([0]=A-high [1]=A-low [2]=B-high [3]=B-low)
//   fault_clr          synchronous clear of the latched shoot-through fault
//   period_cnt         measured primary period in clocks
//   tau1_cnt           primary +1 width in clocks
//   tau2_cnt           secondary +1 width in clocks
//   phi_cnt            signed secondary-minus-primary start offset
//   meas_valid         one-cycle pulse on every output update
//   locked             valid measurement present and switching alive
//   fault              sticky shoot-through flag
// Modports: master drives gates/fault_clr, slave is the monitor.
interface dab_pattern_monitor_if #(
  parameter int CNT_W = 19
);
  logic [3:0]       Sp;
  logic [3:0]       Ss;
  logic             fault_clr;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] tau1_cnt;
  logic [CNT_W-1:0] tau2_cnt;
  logic [CNT_W-1:0] phi_cnt;
  logic             meas_valid;
  logic             locked;
  logic             fault;

  modport master (
    output Sp, Ss, fault_clr,
    input  period_cnt, tau1_cnt, tau2_cnt, phi_cnt, meas_valid, locked, fault
  );

  modport slave (
    input  Sp, Ss, fault_clr,
    output period_cnt, tau1_cnt, tau2_cnt, phi_cnt, meas_valid, locked, fault
  );
endinterface

// File: rtl/dab_pattern_monitor.sv
// rtl/dab_pattern_monitor.sv - gate-pattern decoder measuring period, widths and phase of a DAB modulator
//
// Purpose: synchronizes the primary and secondary gate vectors, decodes each
// bridge's +1 level, measures period / +1 widths / inter-bridge phase in clock
// counts, and flags shoot-through and loss of switching.
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   dab_pattern_monitor_if.slave (Sp, Ss, fault_clr in; measurement outputs out)
// Parameters:
//   CNT_W    width of every count register and output
//   TIMEOUT  cycles without a primary start before lock is dropped
module dab_pattern_monitor #(
  parameter int CNT_W   = 19,
  parameter int TIMEOUT = 500000
) (
  input logic                  clk,
  input logic                  rst,
  dab_pattern_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [3:0]       GATE_POS  = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEAS,
    S_FAULT
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Two synchronizer flops plus one edge-detect stage per gate vector; both
  // bridges see the same latency so relative timing is preserved.
  logic [3:0] sp_s1_q, sp_s2_q, sp_s3_q;
  logic [3:0] ss_s1_q, ss_s2_q, ss_s3_q;

  logic             p_pos_q, p_pos_d, s_pos_q, s_pos_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] w1_q, w1_d, w2_q, w2_d;
  logic [CNT_W-1:0] tau1_q, tau1_d, tau2_q, tau2_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic             tau1_f_q, tau1_f_d, tau2_f_q, tau2_f_d, ph_f_q, ph_f_d;
  state_t           state_q, state_d;

  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] tau1_cnt_q, tau1_cnt_d;
  logic [CNT_W-1:0] tau2_cnt_q, tau2_cnt_d;
  logic [CNT_W-1:0] phi_cnt_q, phi_cnt_d;
  logic             meas_valid_q, meas_valid_d;
  logic             locked_q, locked_d;
  logic             fault_q, fault_d;

  logic             p_start, p_end, s_start, s_end, shoot, timeout;
  logic [CNT_W-1:0] pcnt_inc;

  always_comb begin
    // Only the +1 level matters for measurement; -1 and every other pattern
    // (deadtime, freewheeling) are treated alike as "not +1".
    p_pos_d  = (sp_s3_q == GATE_POS);
    s_pos_d  = (ss_s3_q == GATE_POS);
    p_start  = p_pos_d & ~p_pos_q;
    p_end    = ~p_pos_d & p_pos_q;
    s_start  = s_pos_d & ~s_pos_q;
    s_end    = ~s_pos_d & s_pos_q;
    shoot    = (sp_s3_q[0] & sp_s3_q[1]) | (sp_s3_q[2] & sp_s3_q[3]) |
               (ss_s3_q[0] & ss_s3_q[1]) | (ss_s3_q[2] & ss_s3_q[3]);
    pcnt_inc = sat_inc(pcnt_q);
    timeout  = (pcnt_q >= TIMEOUT_C);

    pcnt_d   = p_start ? CNT_ZERO : pcnt_inc;
    period_d = p_start ? pcnt_inc : period_q;

    // Start cycle is itself a +1 cycle, so a fresh count begins at one.
    w1_d = p_start ? CNT_ONE : (p_pos_d ? sat_inc(w1_q) : w1_q);
    w2_d = s_start ? CNT_ONE : (s_pos_d ? sat_inc(w2_q) : w2_q);
    tau1_d = p_end ? w1_q : tau1_q;
    tau2_d = s_end ? w2_q : tau2_q;

    delay_d = delay_q;
    if (s_start) delay_d = p_start ? CNT_ZERO : pcnt_inc;

    // Flags clear on each primary start, but an event in that same cycle
    // belongs to the period that is just beginning, so set wins over clear.
    tau1_f_d = (tau1_f_q & ~p_start) | p_end;
    tau2_f_d = (tau2_f_q & ~p_start) | s_end;
    ph_f_d   = (ph_f_q   & ~p_start) | s_start;

    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    tau1_cnt_d   = tau1_cnt_q;
    tau2_cnt_d   = tau2_cnt_q;
    phi_cnt_d    = phi_cnt_q;
    meas_valid_d = 1'b0;
    locked_d     = locked_q;
    fault_d      = fault_q;

    if (shoot) begin
      state_d  = S_FAULT;
      fault_d  = 1'b1;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!timeout && p_start) state_d = S_MEAS;
        end
        S_MEAS: begin
          if (timeout) begin
            state_d  = S_IDLE;
            locked_d = 1'b0;
          end else if (p_start && tau1_f_q && tau2_f_q && ph_f_q) begin
            period_cnt_d = pcnt_inc;
            tau1_cnt_d   = tau1_q;
            tau2_cnt_d   = tau2_q;
            // Wrap into -period/2..+period/2; the CNT_W-bit difference is the
            // truncated result of the wider subtraction.
            if ({delay_q, 1'b0} <= {1'b0, pcnt_inc}) phi_cnt_d = delay_q;
            else                                     phi_cnt_d = delay_q - pcnt_inc;
            meas_valid_d = 1'b1;
            locked_d     = 1'b1;
          end
        end
        S_FAULT: begin
          if (bus.fault_clr) begin
            state_d = S_IDLE;
            fault_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_s1_q      <= 4'b0000;
      sp_s2_q      <= 4'b0000;
      sp_s3_q      <= 4'b0000;
      ss_s1_q      <= 4'b0000;
      ss_s2_q      <= 4'b0000;
      ss_s3_q      <= 4'b0000;
      p_pos_q      <= 1'b0;
      s_pos_q      <= 1'b0;
      pcnt_q       <= CNT_ZERO;
      period_q     <= CNT_ZERO;
      w1_q         <= CNT_ZERO;
      w2_q         <= CNT_ZERO;
      tau1_q       <= CNT_ZERO;
      tau2_q       <= CNT_ZERO;
      delay_q      <= CNT_ZERO;
      tau1_f_q     <= 1'b0;
      tau2_f_q     <= 1'b0;
      ph_f_q       <= 1'b0;
      state_q      <= S_IDLE;
      period_cnt_q <= CNT_ZERO;
      tau1_cnt_q   <= CNT_ZERO;
      tau2_cnt_q   <= CNT_ZERO;
      phi_cnt_q    <= CNT_ZERO;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      sp_s1_q      <= bus.Sp;
      sp_s2_q      <= sp_s1_q;
      sp_s3_q      <= sp_s2_q;
      ss_s1_q      <= bus.Ss;
      ss_s2_q      <= ss_s1_q;
      ss_s3_q      <= ss_s2_q;
      p_pos_q      <= p_pos_d;
      s_pos_q      <= s_pos_d;
      pcnt_q       <= pcnt_d;
      period_q     <= period_d;
      w1_q         <= w1_d;
      w2_q         <= w2_d;
      tau1_q       <= tau1_d;
      tau2_q       <= tau2_d;
      delay_q      <= delay_d;
      tau1_f_q     <= tau1_f_d;
      tau2_f_q     <= tau2_f_d;
      ph_f_q       <= ph_f_d;
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      tau1_cnt_q   <= tau1_cnt_d;
      tau2_cnt_q   <= tau2_cnt_d;
      phi_cnt_q    <= phi_cnt_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      fault_q      <= fault_d;
    end
  end

  assign bus.period_cnt = period_cnt_q;
  assign bus.tau1_cnt   = tau1_cnt_q;
  assign bus.tau2_cnt   = tau2_cnt_q;
  assign bus.phi_cnt    = phi_cnt_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.locked     = locked_q;
  assign bus.fault      = fault_q;

endmodule
